// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter slice.
// Contents:
//   WORD_W             - data / address word width of the processor buses
//   DM_ADDR_W          - default number of implemented DataMemory address bits
//   DM_STARVE_LIMIT    - default number of CPU grants allowed while debug waits
//   dm_state_e         - arbiter FSM state encoding
//   dm_owner_e         - which requester owns the access in flight
//   cpu_wins()         - arbitration decision helper
package dm_arbiter_pkg;

    localparam int WORD_W          = 16;
    localparam int DM_ADDR_W       = 8;
    localparam int DM_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        CLEAR = 3'd4
    } dm_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } dm_owner_e;

    // The CPU has priority unless the debug port is waiting and the CPU has
    // already used up its allowance of back-to-back grants.
    function automatic logic cpu_wins(input logic cpu_req,
                                      input logic dbg_req,
                                      input logic at_limit);
        return cpu_req && !(dbg_req && at_limit);
    endfunction

endpackage

// File: rtl/dm_arbiter_clear.sv
// dm_clear_sweeper: address counter for the memory zero-fill.
// Ports:
//   clock, reset - clock and synchronous active-high reset
//   start        - pulse: begin a sweep at address 0
//   busy         - high while the sweep is running
//   addr         - address currently being written
//   done         - high in the cycle that addr holds the last address
module dm_clear_sweeper
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic              busy_r;
    logic [ADDR_W-1:0] addr_r;

    assign busy = busy_r;
    assign addr = addr_r;
    assign done = busy_r && (addr_r == LAST_ADDR);

    // Sweep pointer: loads 0 on start, steps once per cycle, stops after the last address.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 1'b0;
            addr_r <= '0;
        end else if (start) begin
            busy_r <= 1'b1;
            addr_r <= '0;
        end else if (busy_r) begin
            if (addr_r == LAST_ADDR) begin
                busy_r <= 1'b0;
                addr_r <= '0;
            end else begin
                addr_r <= addr_r + ADDR_W'(1);
            end
        end else begin
            busy_r <= busy_r;
            addr_r <= addr_r;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single DataMemory port between the CPU load/store
// path and the debug/loader port, and can zero-fill the whole memory.
// Ports:
//   clock, reset                          - clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata     - CPU request (held until cpu_ack)
//   cpu_ack/cpu_rdata                     - CPU completion pulse and read data
//   dbg_req/dbg_we/dbg_addr/dbg_wdata     - debug request (held until dbg_ack)
//   dbg_ack/dbg_rdata                     - debug completion pulse and read data
//   clear_start/clear_busy                - zero-fill request pulse / in-progress flag
//   mem_address/mem_data/mem_wren         - registered DataMemory drive
//   mem_q                                 - DataMemory read data (one cycle after address)
// Every access takes IDLE -> ISSUE -> WAIT -> ACK; the ack is registered out of
// ACK, so it is seen in the first cycle the FSM is back in IDLE.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DM_ADDR_W,
    parameter int STARVE_LIMIT = DM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [WORD_W-1:0] dbg_addr,
    input  logic [WORD_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [WORD_W-1:0] dbg_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [WORD_W-1:0] mem_q
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    dm_state_e           state_r, state_next_s;
    dm_owner_e           owner_r, owner_next_s;
    logic                op_we_r, op_we_next_s;
    logic [STREAK_W-1:0] streak_r, streak_next_s;
    logic                pend_clear_r, pend_clear_next_s;
    logic [WORD_W-1:0]   mem_address_r, mem_address_next_s;
    logic [WORD_W-1:0]   mem_data_r, mem_data_next_s;
    logic                mem_wren_r, mem_wren_next_s;
    logic                cpu_ack_r, cpu_ack_next_s;
    logic                dbg_ack_r, dbg_ack_next_s;
    logic [WORD_W-1:0]   cpu_rdata_r, cpu_rdata_next_s;
    logic [WORD_W-1:0]   dbg_rdata_r, dbg_rdata_next_s;
    logic                clear_busy_r, clear_busy_next_s;

    logic                cpu_win_s;
    logic                sweep_start_s;
    logic                sw_busy_s;
    logic                sw_done_s;
    logic [ADDR_W-1:0]   sw_addr_s;

    assign cpu_win_s     = cpu_wins(cpu_req, dbg_req, streak_r == STREAK_MAX);
    assign sweep_start_s = (state_r == IDLE) && (clear_start || pend_clear_r);

    dm_clear_sweeper #(
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clock (clock),
        .reset (reset),
        .start (sweep_start_s),
        .busy  (sw_busy_s),
        .addr  (sw_addr_s),
        .done  (sw_done_s)
    );

    assign mem_address = mem_address_r;
    assign mem_data    = mem_data_r;
    assign mem_wren    = mem_wren_r;
    assign cpu_ack     = cpu_ack_r;
    assign dbg_ack     = dbg_ack_r;
    assign cpu_rdata   = cpu_rdata_r;
    assign dbg_rdata   = dbg_rdata_r;
    assign clear_busy  = clear_busy_r;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_next_s       = state_r;
        owner_next_s       = owner_r;
        op_we_next_s       = op_we_r;
        streak_next_s      = streak_r;
        pend_clear_next_s  = pend_clear_r;
        mem_address_next_s = mem_address_r;
        mem_data_next_s    = mem_data_r;
        mem_wren_next_s    = 1'b0;
        cpu_ack_next_s     = 1'b0;
        dbg_ack_next_s     = 1'b0;
        cpu_rdata_next_s   = cpu_rdata_r;
        dbg_rdata_next_s   = dbg_rdata_r;
        clear_busy_next_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (clear_start || pend_clear_r) begin
                    // The first zero write goes out on entry so the sweep
                    // lines up with the sweeper pointer (both start at 0).
                    state_next_s       = CLEAR;
                    pend_clear_next_s  = 1'b0;
                    mem_address_next_s = '0;
                    mem_data_next_s    = '0;
                    mem_wren_next_s    = 1'b1;
                    clear_busy_next_s  = 1'b1;
                end else if (cpu_win_s) begin
                    state_next_s       = ISSUE;
                    owner_next_s       = OWNER_CPU;
                    op_we_next_s       = cpu_we;
                    mem_address_next_s = cpu_addr;
                    mem_data_next_s    = cpu_wdata;
                    mem_wren_next_s    = cpu_we;
                    if (dbg_req) begin
                        streak_next_s = (streak_r == STREAK_MAX) ? STREAK_MAX
                                                                 : streak_r + STREAK_W'(1);
                    end else begin
                        streak_next_s = '0;
                    end
                end else if (dbg_req) begin
                    state_next_s       = ISSUE;
                    owner_next_s       = OWNER_DBG;
                    op_we_next_s       = dbg_we;
                    mem_address_next_s = dbg_addr;
                    mem_data_next_s    = dbg_wdata;
                    mem_wren_next_s    = dbg_we;
                    streak_next_s      = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
                if (clear_start) begin
                    pend_clear_next_s = 1'b1;
                end else begin
                    pend_clear_next_s = pend_clear_r;
                end
            end
            WAIT: begin
                // mem_q now reflects the address presented on entry to ISSUE.
                state_next_s = ACK;
                if (!op_we_r) begin
                    if (owner_r == OWNER_CPU) begin
                        cpu_rdata_next_s = mem_q;
                    end else begin
                        dbg_rdata_next_s = mem_q;
                    end
                end else begin
                    cpu_rdata_next_s = cpu_rdata_r;
                end
                if (clear_start) begin
                    pend_clear_next_s = 1'b1;
                end else begin
                    pend_clear_next_s = pend_clear_r;
                end
            end
            ACK: begin
                state_next_s = IDLE;
                if (owner_r == OWNER_CPU) begin
                    cpu_ack_next_s = 1'b1;
                end else begin
                    dbg_ack_next_s = 1'b1;
                end
                if (clear_start) begin
                    pend_clear_next_s = 1'b1;
                end else begin
                    pend_clear_next_s = pend_clear_r;
                end
            end
            CLEAR: begin
                // clear_start is deliberately not looked at here.
                if (!sw_busy_s || sw_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    mem_address_next_s = WORD_W'(sw_addr_s + ADDR_W'(1));
                    mem_data_next_s    = '0;
                    mem_wren_next_s    = 1'b1;
                    clear_busy_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs and access context.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r       <= OWNER_CPU;
            op_we_r       <= 1'b0;
            streak_r      <= '0;
            pend_clear_r  <= 1'b0;
            mem_address_r <= '0;
            mem_data_r    <= '0;
            mem_wren_r    <= 1'b0;
            cpu_ack_r     <= 1'b0;
            dbg_ack_r     <= 1'b0;
            cpu_rdata_r   <= '0;
            dbg_rdata_r   <= '0;
            clear_busy_r  <= 1'b0;
        end else begin
            owner_r       <= owner_next_s;
            op_we_r       <= op_we_next_s;
            streak_r      <= streak_next_s;
            pend_clear_r  <= pend_clear_next_s;
            mem_address_r <= mem_address_next_s;
            mem_data_r    <= mem_data_next_s;
            mem_wren_r    <= mem_wren_next_s;
            cpu_ack_r     <= cpu_ack_next_s;
            dbg_ack_r     <= dbg_ack_next_s;
            cpu_rdata_r   <= cpu_rdata_next_s;
            dbg_rdata_r   <= dbg_rdata_next_s;
            clear_busy_r  <= clear_busy_next_s;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized
// single-port accesses checked against a word-array memory reference.
module tb_dm_arbiter;

    localparam int AW    = 8;
    localparam int SL    = 4;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = 16'h0, dbg_wdata = 16'h0;
    logic        clear_start = 1'b0;
    logic        cpu_ack, dbg_ack, clear_busy, mem_wren;
    logic [15:0] cpu_rdata, dbg_rdata, mem_address, mem_data;
    logic [15:0] mem_q;

    int checks = 0;
    int failures = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] last_rd [2];
    bit          order_log[$];
    bit          both_acks = 1'b0;

    dm_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // DataMemory stand-in: synchronous write, registered read.
    logic [15:0] mem_model [DEPTH];
    always @(posedge clock) begin
        if (mem_wren) mem_model[mem_address[AW-1:0]] <= mem_data;
        mem_q <= mem_model[mem_address[AW-1:0]];
    end

    // Zero-fill monitor: busy cycles, writes, and writes out of order or non-zero.
    int          busy_cyc = 0, clr_wr = 0, clr_bad = 0;
    logic        prev_busy = 1'b0;
    logic [15:0] clr_exp = 16'h0;
    always @(posedge clock) begin
        prev_busy <= clear_busy;
        if (clear_busy) busy_cyc <= busy_cyc + 1;
        if (clear_busy && mem_wren) begin
            clr_wr <= clr_wr + 1;
            if (mem_data !== 16'h0 || mem_address !== (prev_busy ? clr_exp : 16'h0))
                clr_bad <= clr_bad + 1;
            clr_exp <= mem_address + 16'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input bit port, input bit req, input bit we,
                              input logic [15:0] addr, input logic [15:0] wd);
        if (port == 1'b0) begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        end
    endtask

    // One access from one port; lat counts clock edges until its ack is seen.
    task automatic do_txn(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input int budget,
                          output int lat, output bit other_seen, output logic [15:0] rdata);
        lat = -1; other_seen = 1'b0;
        drive_port(port, 1'b1, we, addr, wd);
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            if ((port ? cpu_ack : dbg_ack) == 1'b1) other_seen = 1'b1;
            if ((port ? dbg_ack : cpu_ack) == 1'b1) begin
                lat = n;
                break;
            end
        end
        rdata = port ? dbg_rdata : cpu_rdata;
        drive_port(port, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic txn_checked(input string tag, input bit port, input bit we,
                               input logic [15:0] addr, input logic [15:0] wd);
        int lat; bit other; logic [15:0] rd;
        do_txn(port, we, addr, wd, 20, lat, other, rd);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_other_ack"}, {31'd0, other}, 32'd0);
        if (we) begin
            ref_mem[addr[AW-1:0]] = wd;
            check({tag, "_rdata_hold"}, rd, last_rd[port]);
        end else begin
            check({tag, "_rdata"}, rd, ref_mem[addr[AW-1:0]]);
            last_rd[port] = ref_mem[addr[AW-1:0]];
        end
    endtask

    // Both ports request reads continuously until n acks have been seen.
    task automatic collect(input int n);
        order_log.delete();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0033;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0000;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (cpu_ack && dbg_ack) both_acks = 1'b1;
            if (cpu_ack) order_log.push_back(1'b0);
            if (dbg_ack) order_log.push_back(1'b1);
            if (order_log.size() >= n) break;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    // With the debug port always waiting, every (SL+1)-th grant goes to debug.
    task automatic check_order(input string tag, input int n);
        check({tag, "_count"}, order_log.size(), n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_grant%0d", tag, i), {31'd0, order_log[i]},
                  {31'd0, ((i % (SL + 1)) == SL)});
    endtask

    task automatic wait_clear_done(input string tag);
        bit ended = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (!clear_busy) begin ended = 1'b1; break; end
        end
        check({tag, "_ends"}, {31'd0, ended}, 32'd1);
        check({tag, "_wren_after"}, {31'd0, mem_wren}, 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
    endtask

    initial begin
        int lat, b0, w0, x0, first_low, ack_at;
        bit early, ack_in_reset;
        logic [15:0] a, d;

        last_rd[0] = 16'h0; last_rd[1] = 16'h0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("rst_mem_address", mem_address, 16'h0);
        check("rst_mem_data", mem_data, 16'h0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        check("rst_dbg_rdata", dbg_rdata, 16'h0);
        reset = 1'b0;
        @(negedge clock);

        // CPU write then read back
        txn_checked("cpu_wr10", 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        txn_checked("cpu_rd10", 1'b0, 1'b0, 16'h0010, 16'h0000);
        check("cpu_rd10_value", cpu_rdata, 16'hBEEF);

        // Debug write, full clear, debug read
        txn_checked("dbg_wr05", 1'b1, 1'b1, 16'h0005, 16'h1234);
        b0 = busy_cyc; w0 = clr_wr; x0 = clr_bad;
        clear_start = 1'b1;
        @(negedge clock);
        clear_start = 1'b0;
        check("clr_busy_rise", {31'd0, clear_busy}, 32'd1);
        wait_clear_done("clr1");
        repeat (2) @(negedge clock);
        check("clr1_busy_cycles", busy_cyc - b0, DEPTH);
        check("clr1_writes", clr_wr - w0, DEPTH);
        check("clr1_bad_writes", clr_bad - x0, 0);
        txn_checked("dbg_rd05", 1'b1, 1'b0, 16'h0005, 16'h0000);
        check("dbg_rd05_zero", dbg_rdata, 16'h0000);

        // Randomized single-port accesses against the reference array
        for (int it = 0; it < 40; it++) begin
            bit p, w;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            d = 16'($urandom);
            txn_checked($sformatf("rnd%0d", it), p, w, a, d);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // Both ports requesting continuously
        collect(10);
        check_order("starve", 10);
        check("starve_no_double_ack", {31'd0, both_acks}, 32'd0);
        @(negedge clock);

        // clear_start while the CPU access is in WAIT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        @(negedge clock);
        @(negedge clock);
        clear_start = 1'b1;
        @(negedge clock);
        clear_start = 1'b0;
        @(negedge clock);
        check("wclr_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        check("wclr_busy_before", {31'd0, clear_busy}, 32'd0);
        check("wclr_rdata", cpu_rdata, ref_mem[5]);
        cpu_req = 1'b0;
        @(negedge clock);
        check("wclr_busy_after", {31'd0, clear_busy}, 32'd1);
        check("wclr_ack_single", {31'd0, cpu_ack}, 32'd0);
        wait_clear_done("clr2");

        // CPU request raised during a clear
        clear_start = 1'b1;
        @(negedge clock);
        clear_start = 1'b0;
        check("rclr_busy", {31'd0, clear_busy}, 32'd1);
        repeat (5) @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        early = 1'b0; first_low = -1; ack_at = -1;
        for (int k = 1; k < 400; k++) begin
            @(negedge clock);
            if (clear_busy && cpu_ack) early = 1'b1;
            if (!clear_busy && first_low < 0) first_low = k;
            if (cpu_ack) begin ack_at = k; break; end
        end
        cpu_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
        check("rclr_no_early_ack", {31'd0, early}, 32'd0);
        check("rclr_ack_after_idle", ack_at - first_low, 4);
        check("rclr_rdata", cpu_rdata, 16'h0000);
        @(negedge clock);

        // Reset in ISSUE of a CPU write
        txn_checked("r42_wr33", 1'b0, 1'b1, 16'h0033, 16'hA5A5);
        collect(3);
        check_order("pre_rst", 3);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0077; cpu_wdata = 16'h5A5A;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0000;
        @(negedge clock);
        check("r42_issue_wren", {31'd0, mem_wren}, 32'd1);
        check("r42_issue_addr", mem_address, 16'h0077);
        reset = 1'b1;
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0;
        @(negedge clock);
        // the write was already on the port at the reset edge
        ref_mem[8'h77] = 16'h5A5A;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        check("r42_wren", {31'd0, mem_wren}, 32'd0);
        check("r42_addr", mem_address, 16'h0);
        check("r42_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("r42_cpu_rdata", cpu_rdata, 16'h0);
        check("r42_clear_busy", {31'd0, clear_busy}, 32'd0);
        reset = 1'b0;
        ack_in_reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (cpu_ack || dbg_ack) ack_in_reset = 1'b1;
        end
        check("r42_no_ack", {31'd0, ack_in_reset}, 32'd0);
        collect(5);
        check_order("post_rst", 5);
        @(negedge clock);
        txn_checked("r42_rd33", 1'b0, 1'b0, 16'h0033, 16'h0000);
        check("r42_mem_kept", cpu_rdata, 16'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, is the number of implemented DataMemory address bits (depth 2^ADDR_W words).
REQ-002 Parameter STARVE_LIMIT, default 4, is the number of consecutive CPU grants allowed while dbg_req is pending.
REQ-003 Port clock, input, 1, is the single clock; all logic updates on posedge clock.
REQ-004 Port reset, input, 1, is the synchronous, active-high reset.
REQ-005 Ports cpu_req, cpu_we, cpu_addr, cpu_wdata are inputs of widths 1/1/16/16 carrying the core's load/store request.
REQ-006 Ports cpu_ack and cpu_rdata are outputs of widths 1/16: completion pulse and read data.
REQ-007 Ports dbg_req, dbg_we, dbg_addr, dbg_wdata are inputs of widths 1/1/16/16 carrying the debug/loader port request.
REQ-008 Ports dbg_ack and dbg_rdata are outputs of widths 1/16, with the same meaning for the debug port.
REQ-009 Port clear_start, input, 1, is a pulse requesting zero-fill of the whole memory.
REQ-010 Port clear_busy, output, 1, is high while the zero-fill runs.
REQ-011 Ports mem_address, mem_data, mem_wren are registered outputs of widths 16/16/1 driving the DataMemory port.
REQ-012 Port mem_q, input, 16, is the DataMemory read data, valid the cycle after its address is presented.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK and CLEAR.
REQ-014 In IDLE with a pending clear (clear_start or latched flag), the FSM SHALL go to CLEAR; this beats all requests.
REQ-015 In IDLE with no pending clear, the arbiter SHALL grant cpu_req unless dbg_req is high and the streak counter equals STARVE_LIMIT; otherwise it SHALL grant dbg_req; with no request it SHALL stay in IDLE.
REQ-016 Every grant SHALL register the winner's addr, wdata and we into mem_address, mem_data and mem_wren and move to ISSUE.
REQ-017 ISSUE SHALL go to WAIT, clearing mem_wren to 0 at that edge.
REQ-018 WAIT SHALL capture mem_q into the winner's rdata register on reads only; rdata SHALL hold between reads.
REQ-019 ACK SHALL assert only the winner's ack for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be a request sampled in IDLE at edge E0 producing ack high in the cycle after edge E3, for reads and writes alike.
REQ-021 Requesters SHALL hold req and operands stable until ack; a request dropped before ack SHALL still complete its access.
REQ-022 The streak counter SHALL increment, saturating at STARVE_LIMIT, on a CPU grant while dbg_req is high.
REQ-023 The streak counter SHALL clear on any debug grant and on a CPU grant with dbg_req low.
REQ-024 CLEAR SHALL write 0 to addresses 0 .. 2^ADDR_W-1, one per cycle, in ascending order, with upper address bits 0.
REQ-025 CLEAR SHALL hold clear_busy high throughout, then return to IDLE after the last address with mem_wren low.
REQ-026 A clear_start outside IDLE and CLEAR SHALL be latched and executed on the next IDLE.
REQ-027 A clear_start during CLEAR SHALL be ignored.
REQ-028 Requests arriving during CLEAR SHALL wait, with no ack, until CLEAR ends.
REQ-029 Simultaneous cpu_req and dbg_req with streak below STARVE_LIMIT SHALL grant CPU.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE.
REQ-031 On reset, mem_wren, cpu_ack, dbg_ack and clear_busy SHALL be 0.
REQ-032 On reset, mem_address, mem_data, cpu_rdata, dbg_rdata, the streak counter, the clear pointer and the pending-clear flag SHALL be 0.
REQ-033 Reset mid-transaction or mid-CLEAR SHALL abort it with no ack.
REQ-034 Reset SHALL not alter memory contents already written.

Structure
REQ-035 The FSM state enum, the 16-bit word width and the default ADDR_W/STARVE_LIMIT SHALL live in the shared package used by the processor blocks.
REQ-036 The zero-fill address counter SHALL be one sub-module, dm_clear_sweeper (start, busy, addr, done); arbitration and FSM stay in dm_arbiter.

Verification
REQ-037 CPU write addr 0x0010 data 0xBEEF, then CPU read 0x0010 -> each cpu_ack at E3; cpu_rdata=0xBEEF; dbg_ack never high.
REQ-038 cpu_req and dbg_req held high continuously, STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,DBG repeating.
REQ-039 Debug write 0x1234 to 0x0005, then clear_start, then debug read 0x0005 -> clear_busy high exactly 256 cycles with 256 writes of 0 at addresses 0..255; read returns 0x0000.
REQ-040 clear_start during CPU WAIT state -> CPU ack completes first; CLEAR starts on the following IDLE.
REQ-041 cpu_req raised during CLEAR -> no ack until clear_busy falls; ack at E3 after the first IDLE.
REQ-042 Reset asserted in ISSUE of a CPU write -> no cpu_ack; mem_wren 0 after the reset edge; FSM in IDLE; streak counter 0.
